// File: rtl/key_cfg_ctrl.sv
// key_cfg_ctrl
//   Key front-end for the DDS/DAC generator. The eight active-low board keys
//   are synchronised and debounced. Key presses edit a pending configuration
//   (frequency step, waveform, amplitude). A commit press copies the pending
//   set to the active set, and the DDS core reads only the active set.
//
// Ports
//   clk_50M    in   1   system clock
//   rst        in   1   asynchronous reset, active-high
//   key_in     in   8   raw keys, active-low
//                       [0] freq up  [1] freq down  [2] wave next  [3] amp next
//                       [4] commit   [5] defaults   [7:6] spare
//   key_pulse  out  8   one-cycle strobe per debounced press
//   freq_word  out  32  active phase increment, BASE_WORD*(idx+1)
//   wave_sel   out  2   active waveform: 0 sine, 1 square, 2 triangle, 3 saw
//   amp_sel    out  3   active amplitude code, 7 = full scale
//   cfg_valid  out  1   strobe: active set updated this cycle
//   cfg_dirty  out  1   pending set differs from active set
//
// Control FSM states
//   state  | meaning
//   S_IDLE | pending set equals active set
//   S_EDIT | pending set has been edited since the last commit/defaults

module key_cfg_ctrl #(
   parameter int          DEBOUNCE_CYCLES = 1000,
   parameter int          FREQ_STEPS      = 16,
   parameter logic [31:0] BASE_WORD       = 32'd85899
) (
   input  logic        clk_50M,
   input  logic        rst,
   input  logic [7:0]  key_in,
   output logic [7:0]  key_pulse,
   output logic [31:0] freq_word,
   output logic [1:0]  wave_sel,
   output logic [2:0]  amp_sel,
   output logic        cfg_valid,
   output logic        cfg_dirty
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int IDX_W = (FREQ_STEPS > 1) ? $clog2(FREQ_STEPS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(FREQ_STEPS - 1);
   localparam logic [1:0]       WAVE_DEF = 2'd0;
   localparam logic [2:0]       AMP_DEF  = 3'd7;

   typedef enum logic {S_IDLE, S_EDIT} state_t;

   // ---------------------------------------------------------------
   // Input path: 2-FF synchroniser, then per-key stable reg + counter
   // ---------------------------------------------------------------
   logic [7:0]       r_sync1;
   logic [7:0]       r_sync2;
   logic [7:0]       r_stable;
   logic [CNT_W-1:0] r_cnt [8];
   logic [7:0]       r_pulse;

   always_ff @(posedge clk_50M or posedge rst) begin
      if (rst) begin
         r_sync1  <= '1;
         r_sync2  <= '1;
         r_stable <= '1;
         r_pulse  <= '0;
         for (int i = 0; i < 8; i++) r_cnt[i] <= '0;
      end else begin
         r_sync1 <= key_in;
         r_sync2 <= r_sync1;
         r_pulse <= '0;
         for (int i = 0; i < 8; i++) begin
            if (r_sync2[i] != r_stable[i]) begin
               if (r_cnt[i] == CNT_LAST) begin
                  r_stable[i] <= r_sync2[i];
                  r_cnt[i]    <= '0;
                  // stable was 1 and is about to become 0: a press
                  r_pulse[i]  <= r_stable[i];
               end else begin
                  r_cnt[i] <= r_cnt[i] + CNT_W'(1);
               end
            end else begin
               r_cnt[i] <= '0;
            end
         end
      end
   end

   assign key_pulse = r_pulse;

   // ---------------------------------------------------------------
   // Control FSM with pending/active configuration
   // ---------------------------------------------------------------
   state_t           r_state;
   logic [IDX_W-1:0] r_pend_idx;
   logic [1:0]       r_pend_wave;
   logic [2:0]       r_pend_amp;
   logic [IDX_W-1:0] r_act_idx;
   logic [1:0]       r_act_wave;
   logic [2:0]       r_act_amp;
   logic [31:0]      r_freq;
   logic             r_valid;
   logic             r_dirty;

   logic             w_edit;
   logic [31:0]      w_freq_pend;

   assign w_edit      = |r_pulse[3:0];
   assign w_freq_pend = BASE_WORD * (32'(r_pend_idx) + 32'd1);

   always_ff @(posedge clk_50M or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_pend_idx  <= '0;
         r_pend_wave <= WAVE_DEF;
         r_pend_amp  <= AMP_DEF;
         r_act_idx   <= '0;
         r_act_wave  <= WAVE_DEF;
         r_act_amp   <= AMP_DEF;
         r_freq      <= BASE_WORD;
         r_valid     <= 1'b0;
         r_dirty     <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         r_dirty <= ({r_pend_idx, r_pend_wave, r_pend_amp} !=
                     {r_act_idx,  r_act_wave,  r_act_amp});

         if (r_pulse[5]) begin
            r_pend_idx  <= '0;
            r_pend_wave <= WAVE_DEF;
            r_pend_amp  <= AMP_DEF;
            r_act_idx   <= '0;
            r_act_wave  <= WAVE_DEF;
            r_act_amp   <= AMP_DEF;
            r_freq      <= BASE_WORD;
            r_valid     <= 1'b1;
            r_state     <= S_IDLE;
         end else if (r_pulse[4]) begin
            // In IDLE pending already equals active, so only the strobe is needed
            if (r_state == S_EDIT) begin
               r_act_idx  <= r_pend_idx;
               r_act_wave <= r_pend_wave;
               r_act_amp  <= r_pend_amp;
               r_freq     <= w_freq_pend;
            end
            r_valid <= 1'b1;
            r_state <= S_IDLE;
         end else if (w_edit) begin
            // up and down together cancel
            if (r_pulse[0] && !r_pulse[1] && (r_pend_idx != IDX_MAX))
               r_pend_idx <= r_pend_idx + IDX_W'(1);
            else if (r_pulse[1] && !r_pulse[0] && (r_pend_idx != '0))
               r_pend_idx <= r_pend_idx - IDX_W'(1);
            if (r_pulse[2]) r_pend_wave <= r_pend_wave + 2'd1;
            if (r_pulse[3]) r_pend_amp  <= r_pend_amp + 3'd1;
            r_state <= S_EDIT;
         end
      end
   end

   assign freq_word = r_freq;
   assign wave_sel  = r_act_wave;
   assign amp_sel   = r_act_amp;
   assign cfg_valid = r_valid;
   assign cfg_dirty = r_dirty;

endmodule

// File: tb/tb_key_cfg_ctrl.sv
module tb_key_cfg_ctrl;

   localparam int          D    = 100;
   localparam logic [31:0] BASE = 32'd85899;

   logic        clk_50M = 1'b0;
   logic        rst;
   logic [7:0]  key_in;
   logic [7:0]  key_pulse;
   logic [31:0] freq_word;
   logic [1:0]  wave_sel;
   logic [2:0]  amp_sel;
   logic        cfg_valid;
   logic        cfg_dirty;

   key_cfg_ctrl #(
      .DEBOUNCE_CYCLES(D),
      .FREQ_STEPS(16),
      .BASE_WORD(BASE)
   ) u_dut (
      .clk_50M   (clk_50M),
      .rst       (rst),
      .key_in    (key_in),
      .key_pulse (key_pulse),
      .freq_word (freq_word),
      .wave_sel  (wave_sel),
      .amp_sel   (amp_sel),
      .cfg_valid (cfg_valid),
      .cfg_dirty (cfg_dirty)
   );

   always #10 clk_50M = ~clk_50M;

   int cyc = 0;
   always @(posedge clk_50M) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   typedef struct {logic [7:0] mask; int due;} pulse_t;
   typedef struct {logic [31:0] freq; logic [1:0] wave; logic [2:0] amp; int due;} cfg_t;
   pulse_t q_pulse[$];
   cfg_t   q_cfg[$];
   pulse_t e_pulse;
   cfg_t   e_cfg;

   // reference model of pending / active sets
   int m_p_idx, m_p_wave, m_p_amp, m_a_idx, m_a_wave, m_a_amp;

   function automatic logic [31:0] fw(input int idx);
      return BASE * 32'(idx + 1);
   endfunction

   function automatic logic m_dirty();
      return (m_p_idx != m_a_idx) || (m_p_wave != m_a_wave) || (m_p_amp != m_a_amp);
   endfunction

   task automatic m_defaults();
      m_p_idx = 0; m_p_wave = 0; m_p_amp = 7;
      m_a_idx = 0; m_a_wave = 0; m_a_amp = 7;
   endtask

   task automatic m_apply(input logic [7:0] m, input int due);
      cfg_t c;
      if (m[5]) begin
         m_defaults();
      end else if (m[4]) begin
         m_a_idx = m_p_idx; m_a_wave = m_p_wave; m_a_amp = m_p_amp;
      end else begin
         if (m[0] && !m[1] && m_p_idx < 15) m_p_idx++;
         if (m[1] && !m[0] && m_p_idx > 0)  m_p_idx--;
         if (m[2]) m_p_wave = (m_p_wave + 1) % 4;
         if (m[3]) m_p_amp  = (m_p_amp + 1) % 8;
      end
      if (m[5] || m[4]) begin
         c.freq = fw(m_a_idx);
         c.wave = 2'(m_a_wave);
         c.amp  = 3'(m_a_amp);
         c.due  = due + 1;
         q_cfg.push_back(c);
      end
   endtask

   // press keys in mask together, hold 1.5*D, release 1.5*D
   task automatic press(input logic [7:0] m);
      pulse_t p;
      @(negedge clk_50M);
      key_in = key_in & ~m;
      p.mask = m;
      p.due  = cyc + D + 2;
      q_pulse.push_back(p);
      m_apply(m, p.due);
      repeat (D + D/2) @(negedge clk_50M);
      key_in = key_in | m;
      repeat (D + D/2) @(negedge clk_50M);
   endtask

   // scoreboard monitor
   always @(negedge clk_50M) begin
      if (!rst) begin
         if (key_pulse != 8'h00) begin
            if (q_pulse.size() == 0) begin
               chk("pulse_unexpected", 32'(key_pulse), 32'd0);
            end else begin
               e_pulse = q_pulse.pop_front();
               chk("pulse_mask", 32'(key_pulse), 32'(e_pulse.mask));
               chk("pulse_cycle", cyc, e_pulse.due);
            end
         end
         if (cfg_valid) begin
            if (q_cfg.size() == 0) begin
               chk("cfg_valid_unexpected", 32'(cfg_valid), 32'd0);
            end else begin
               e_cfg = q_cfg.pop_front();
               chk("cfg_freq", freq_word, e_cfg.freq);
               chk("cfg_wave", 32'(wave_sel), 32'(e_cfg.wave));
               chk("cfg_amp", 32'(amp_sel), 32'(e_cfg.amp));
               chk("cfg_cycle", cyc, e_cfg.due);
            end
         end
      end
   end

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_freq"}, freq_word, 32'd85899);
      chk({tag, "_wave"}, 32'(wave_sel), 32'd0);
      chk({tag, "_amp"}, 32'(amp_sel), 32'd7);
      chk({tag, "_valid"}, 32'(cfg_valid), 32'd0);
      chk({tag, "_pulse"}, 32'(key_pulse), 32'd0);
      chk({tag, "_dirty"}, 32'(cfg_dirty), 32'd0);
   endtask

   initial begin
      key_in = 8'hFF;
      rst    = 1'b1;
      m_defaults();
      #20;
      rst = 1'b0;
      #1;
      chk_reset_vals("reset");

      // short glitch below debounce threshold
      @(negedge clk_50M);
      key_in[0] = 1'b0;
      repeat (D/2) @(negedge clk_50M);
      key_in[0] = 1'b1;
      repeat (2*D) @(negedge clk_50M);
      chk("glitch_dirty", 32'(cfg_dirty), 32'd0);

      // three freq-up presses then commit
      for (int i = 0; i < 3; i++) press(8'h01);
      chk("t3_dirty_pending", 32'(cfg_dirty), 32'(m_dirty()));
      chk("t3_dirty_is_1", 32'(cfg_dirty), 32'd1);
      press(8'h10);
      chk("t3_freq", freq_word, 32'd343596);
      chk("t3_dirty_after", 32'(cfg_dirty), 32'd0);

      // back to idx 0, then down at 0 saturates; pending equals active
      press(8'h20);
      press(8'h02);
      chk("t4_down_sat_dirty", 32'(cfg_dirty), 32'd0);
      for (int i = 0; i < 17; i++) press(8'h01);
      press(8'h10);
      chk("t4_freq_sat", freq_word, 32'd1374384);

      // waveform and amplitude wrap
      for (int i = 0; i < 5; i++) press(8'h04);
      for (int i = 0; i < 2; i++) press(8'h08);
      chk("t5_dirty", 32'(cfg_dirty), 32'(m_dirty()));
      press(8'h10);
      chk("t5_wave", 32'(wave_sel), 32'd1);
      chk("t5_amp", 32'(amp_sel), 32'd1);

      // up+down together, then commit with a same-cycle wave edit (dropped)
      press(8'h01 | 8'h02);
      chk("t5_updown_dirty", 32'(cfg_dirty), 32'd0);
      press(8'h10 | 8'h04);
      chk("t5_commit_drop_wave", 32'(wave_sel), 32'd1);
      chk("t5_commit_drop_dirty", 32'(cfg_dirty), 32'd0);

      // pending edits then defaults
      press(8'h04);
      press(8'h08);
      chk("t6_dirty_before", 32'(cfg_dirty), 32'd1);
      press(8'h20);
      chk("t6_freq", freq_word, 32'd85899);
      chk("t6_wave", 32'(wave_sel), 32'd0);
      chk("t6_amp", 32'(amp_sel), 32'd7);
      chk("t6_dirty", 32'(cfg_dirty), 32'd0);

      // spare keys: pulses only
      press(8'hC0);
      chk("spare_dirty", 32'(cfg_dirty), 32'd0);

      // move active off defaults, then reset in the middle of a key3 hold
      press(8'h01);
      press(8'h10);
      chk("pre_rst_freq", freq_word, fw(1));
      @(negedge clk_50M);
      key_in[3] = 1'b0;
      repeat (D/2 + 10) @(negedge clk_50M);
      rst    = 1'b1;
      key_in = 8'hFF;
      m_defaults();
      #1;
      chk_reset_vals("midrst");
      repeat (2) @(negedge clk_50M);
      rst = 1'b0;
      repeat (3*D) @(negedge clk_50M);
      chk_reset_vals("post_rst");

      chk("q_pulse_left", q_pulse.size(), 0);
      chk("q_cfg_left", q_cfg.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
